// File: rtl/ext_mem_writer_if.sv
// Bus bundle between an external-memory byte stream source and ext_mem_writer.
// With EXT_MEM_WRITER_CHECKSUM_EN defined the bundle also carries a 16-bit checksum.
interface ext_mem_writer_if #(
   parameter int ADDR_W = 16
);
   // Stream handshake: valid-only (Lock). Every rising edge with Lock=1 transfers din;
   // there is no ready/backpressure, so the receiver must absorb one byte per cycle.
   logic              Start;
   logic              Lock;
   logic [7:0]        din;
   logic [ADDR_W-1:0] rd_addr;
   logic [7:0]        rd_data;
   logic [ADDR_W-1:0] wr_addr;
   logic              Busy;
   logic              Done;
   logic              Overflow;
`ifdef EXT_MEM_WRITER_CHECKSUM_EN
   logic [15:0]       checksum;

   modport master (
      output Start, Lock, din, rd_addr,
      input  rd_data, wr_addr, Busy, Done, Overflow, checksum
   );
   modport slave (
      input  Start, Lock, din, rd_addr,
      output rd_data, wr_addr, Busy, Done, Overflow, checksum
   );
`else
   modport master (
      output Start, Lock, din, rd_addr,
      input  rd_data, wr_addr, Busy, Done, Overflow
   );
   modport slave (
      input  Start, Lock, din, rd_addr,
      output rd_data, wr_addr, Busy, Done, Overflow
   );
`endif
endinterface

// File: rtl/ext_mem_writer.sv
// Captures a Lock-qualified byte stream into an on-chip buffer after discarding SKIP priming bytes.
// Optional running byte checksum is enabled by defining EXT_MEM_WRITER_CHECKSUM_EN.
module ext_mem_writer #(
   parameter int DEPTH  = 65536,
   parameter int ADDR_W = 16,
   parameter int SKIP   = 2
) (
   input  logic                CLK,
   input  logic                RST,
   ext_mem_writer_if.slave     bus,
   output logic [1:0]          dbg_state
);

   localparam int SKIP_W = (SKIP < 2) ? 1 : $clog2(SKIP);
   localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'((SKIP > 0) ? SKIP - 1 : 0);
   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SKIP  = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic [SKIP_W-1:0]   skip_cnt_q, skip_cnt_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                overflow_q, overflow_d;
   logic [7:0]          rd_data_q, rd_data_d;
   logic                wr_en;
   logic                arm;

   logic [7:0]          mem [DEPTH];

`ifdef EXT_MEM_WRITER_CHECKSUM_EN
   logic [15:0]         checksum_q, checksum_d;
`endif

   // Start is only honoured when no capture is in flight.
   assign arm = bus.Start && ((state_q == S_IDLE) || (state_q == S_DONE));

   always_comb begin
      state_d    = state_q;
      wr_addr_d  = wr_addr_q;
      skip_cnt_d = skip_cnt_q;
      overflow_d = overflow_q;
      wr_en      = 1'b0;
`ifdef EXT_MEM_WRITER_CHECKSUM_EN
      checksum_d = checksum_q;
`endif
      if (arm) begin
         state_d    = (SKIP == 0) ? S_WRITE : S_SKIP;
         wr_addr_d  = '0;
         skip_cnt_d = '0;
         overflow_d = 1'b0;
`ifdef EXT_MEM_WRITER_CHECKSUM_EN
         checksum_d = '0;
`endif
      end else begin
         case (state_q)
            S_SKIP: begin
               if (bus.Lock) begin
                  skip_cnt_d = skip_cnt_q + SKIP_W'(1);
                  if (skip_cnt_q == SKIP_LAST) state_d = S_WRITE;
               end
            end
            S_WRITE: begin
               if (bus.Lock) begin
                  wr_en     = 1'b1;
                  wr_addr_d = wr_addr_q + ADDR_W'(1);
`ifdef EXT_MEM_WRITER_CHECKSUM_EN
                  checksum_d = checksum_q + {8'h00, bus.din};
`endif
                  if (wr_addr_q == ADDR_LAST) state_d = S_DONE;
               end
            end
            S_DONE: begin
               if (bus.Lock) overflow_d = 1'b1;
            end
            default: ;
         endcase
      end
      // Status flags are decoded from the next state so they move with the state register.
      busy_d    = (state_d == S_SKIP) || (state_d == S_WRITE);
      done_d    = (state_d == S_DONE);
      rd_data_d = mem[bus.rd_addr];
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= S_IDLE;
         wr_addr_q  <= '0;
         skip_cnt_q <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         overflow_q <= 1'b0;
         rd_data_q  <= '0;
`ifdef EXT_MEM_WRITER_CHECKSUM_EN
         checksum_q <= '0;
`endif
      end else begin
         state_q    <= state_d;
         wr_addr_q  <= wr_addr_d;
         skip_cnt_q <= skip_cnt_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         overflow_q <= overflow_d;
         rd_data_q  <= rd_data_d;
`ifdef EXT_MEM_WRITER_CHECKSUM_EN
         checksum_q <= checksum_d;
`endif
      end
   end

   // Buffer is deliberately left out of reset so a partial capture survives RST.
   always_ff @(posedge CLK) begin
      if (wr_en) mem[wr_addr_q] <= bus.din;
   end

   assign bus.rd_data  = rd_data_q;
   assign bus.wr_addr  = wr_addr_q;
   assign bus.Busy     = busy_q;
   assign bus.Done     = done_q;
   assign bus.Overflow = overflow_q;
`ifdef EXT_MEM_WRITER_CHECKSUM_EN
   assign bus.checksum = checksum_q;
`endif
   assign dbg_state    = state_q;

endmodule
